// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word fall-through receive FIFO.
// Errors are reported as one-cycle registered pulses following the stop-bit sample.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;

  localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shift;
  logic               r_frame_err;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_rx_prev;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overrun;

  logic               w_rx_s;
  logic               w_stop_sample;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_wr;

  // Synchronizer flops and the edge-detect history idle high, matching the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx_i;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (r_rx_prev && !w_rx_s) r_state <= START;
        end
        START: begin
          if (r_cnt == HALF_C) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= w_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (r_cnt == LAST_C) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (r_cnt == LAST_C) begin
            r_cnt       <= '0;
            r_frame_err <= !w_rx_s;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_stop_sample = (r_state == STOP) && (r_cnt == LAST_C);
  assign w_push        = w_stop_sample && w_rx_s;
  assign w_full        = (r_count == DEPTH_C);
  assign w_pop         = (r_count != '0) && rx_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
  assign w_wr          = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign rx_data     = r_mem[r_rd_ptr];
  assign rx_valid    = (r_count != '0);
  assign fifo_count  = r_count;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit and a 4-entry FIFO.
// A negedge monitor records pops and error pulses for the scenario tasks to inspect.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_bad = 0;
  int n_fe, n_oe, n_both, n_valid;
  logic [7:0] popped [$];

  uart_rx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_i),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun_err(overrun_err), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) n_fe++;
      if (overrun_err) n_oe++;
      if (frame_err && overrun_err) n_both++;
      if (rx_valid) n_valid++;
      if (rx_valid && rx_ready) popped.push_back(rx_data);
    end
  end

  function automatic logic [7:0] pk(input int i);
    return (i < popped.size()) ? popped[i] : 8'hxx;
  endfunction

  task automatic clear_mon();
    n_fe = 0; n_oe = 0; n_both = 0; n_valid = 0;
    popped.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    $display("send 0x%02h stop=%0b", d, stop_bit);
    @(posedge clk); #1 rx_i = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_i = d[i];
      repeat (16) @(posedge clk);
    end
    #1 rx_i = stop_bit;
    repeat (16) @(posedge clk);
    #1 rx_i = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", rx_valid); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rst_data got=%h exp=00", rx_data); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", fifo_count); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
    n_cmp++; if (overrun_err !== 1'b0) begin n_bad++; $display("FAIL rst_overrun got=%b exp=0", overrun_err); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_single_byte();
    clear_mon();
    rx_ready = 1'b1;
    send_byte(8'hA5, 1'b1);
    repeat (30) @(posedge clk);
    n_cmp++; if (popped.size() !== 1) begin n_bad++; $display("FAIL a5_npop got=%0d exp=1", popped.size()); end
    n_cmp++; if (pk(0) !== 8'hA5) begin n_bad++; $display("FAIL a5_data got=%h exp=a5", pk(0)); end
    n_cmp++; if (n_valid !== 1) begin n_bad++; $display("FAIL a5_valid_cycles got=%0d exp=1", n_valid); end
    n_cmp++; if (n_fe + n_oe !== 0) begin n_bad++; $display("FAIL a5_errs got=%0d exp=0", n_fe + n_oe); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL a5_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_glitch();
    clear_mon();
    $display("glitch low 4 cycles");
    @(posedge clk); #1 rx_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_i = 1'b1;
    repeat (200) @(posedge clk);
    n_cmp++; if (n_valid !== 0) begin n_bad++; $display("FAIL glitch_valid got=%0d exp=0", n_valid); end
    n_cmp++; if (n_fe + n_oe !== 0) begin n_bad++; $display("FAIL glitch_errs got=%0d exp=0", n_fe + n_oe); end
    send_byte(8'h5A, 1'b1);
    repeat (30) @(posedge clk);
    n_cmp++; if (popped.size() !== 1 || pk(0) !== 8'h5A) begin n_bad++; $display("FAIL glitch_next got=%h n=%0d exp=5a n=1", pk(0), popped.size()); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_byte(8'h3C, 1'b0);
    repeat (30) @(posedge clk);
    n_cmp++; if (n_fe !== 1) begin n_bad++; $display("FAIL fe_pulses got=%0d exp=1", n_fe); end
    n_cmp++; if (n_oe !== 0) begin n_bad++; $display("FAIL fe_overrun got=%0d exp=0", n_oe); end
    n_cmp++; if (popped.size() !== 0 || fifo_count !== 3'd0) begin n_bad++; $display("FAIL fe_dropped got n=%0d cnt=%0d exp 0/0", popped.size(), fifo_count); end
    send_byte(8'h11, 1'b1);
    repeat (30) @(posedge clk);
    n_cmp++; if (popped.size() !== 1 || pk(0) !== 8'h11) begin n_bad++; $display("FAIL fe_next got=%h n=%0d exp=11 n=1", pk(0), popped.size()); end
  endtask

  task automatic test_overrun();
    clear_mon();
    rx_ready = 1'b0;
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1);
    repeat (30) @(posedge clk);
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL ovr_count got=%0d exp=4", fifo_count); end
    n_cmp++; if (n_oe !== 1) begin n_bad++; $display("FAIL ovr_pulses got=%0d exp=1", n_oe); end
    n_cmp++; if (n_fe !== 0 || n_both !== 0) begin n_bad++; $display("FAIL ovr_fe got=%0d/%0d exp=0/0", n_fe, n_both); end
    n_cmp++; if (rx_data !== 8'h01) begin n_bad++; $display("FAIL ovr_head got=%h exp=01", rx_data); end
    clear_mon();
    @(posedge clk); #1 rx_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 rx_ready = 1'b0;
    n_cmp++; if (popped.size() !== 4) begin n_bad++; $display("FAIL ovr_npop got=%0d exp=4", popped.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (pk(i) !== 8'(i + 1)) begin n_bad++; $display("FAIL ovr_pop%0d got=%h exp=%h", i, pk(i), 8'(i + 1)); end
    end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL ovr_drain got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_full_push_pop();
    clear_mon();
    rx_ready = 1'b0;
    for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b1);
    repeat (5) @(posedge clk);
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL full_fill got=%0d exp=4", fifo_count); end
    clear_mon();
    // The stop bit is sampled on the 155th edge after the edge that launches the start bit.
    fork
      send_byte(8'h77, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL full_pp_count got=%0d exp=4", fifo_count); end
    n_cmp++; if (n_oe !== 0) begin n_bad++; $display("FAIL full_pp_overrun got=%0d exp=0", n_oe); end
    @(posedge clk); #1 rx_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 rx_ready = 1'b0;
    n_cmp++; if (popped.size() !== 5) begin n_bad++; $display("FAIL full_pp_npop got=%0d exp=5", popped.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (pk(i) !== 8'(i + 1)) begin n_bad++; $display("FAIL full_pp_pop%0d got=%h exp=%h", i, pk(i), 8'(i + 1)); end
    end
    n_cmp++; if (pk(4) !== 8'h77) begin n_bad++; $display("FAIL full_pp_last got=%h exp=77", pk(4)); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    rx_ready = 1'b0;
    send_byte(8'h42, 1'b1);
    repeat (5) @(posedge clk);
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL mid_pre got=%0d exp=1", fifo_count); end
    // Bits 4..7 of 0xF0 are high, so the line shows no falling edge once reset lifts.
    fork
      send_byte(8'hF0, 1'b1);
      begin
        @(posedge clk);
        repeat (87) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({rx_valid, frame_err, overrun_err} !== 3'b000) begin n_bad++; $display("FAIL mid_flags got=%b exp=000", {rx_valid, frame_err, overrun_err}); end
        n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL mid_data got=%h exp=00", rx_data); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    repeat (30) @(posedge clk);
    n_cmp++; if (fifo_count !== 3'd0 || n_fe !== 0) begin n_bad++; $display("FAIL mid_nobyte got cnt=%0d fe=%0d exp 0/0", fifo_count, n_fe); end
    clear_mon();
    rx_ready = 1'b1;
    send_byte(8'hC3, 1'b1);
    repeat (30) @(posedge clk);
    n_cmp++; if (popped.size() !== 1 || pk(0) !== 8'hC3) begin n_bad++; $display("FAIL mid_next got=%h n=%0d exp=c3 n=1", pk(0), popped.size()); end
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_i     = 1'b1;
    rx_ready = 1'b0;
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_push_pop();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud); legal values are 4 or more.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, meaning receive FIFO entries; legal values are powers of 2, 2 or more.
REQ-003 SHALL provide port clk  input  1  system clock; all logic rises on its edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port rx_i  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 SHALL provide port rx_data  output  8  byte at the FIFO head (first-word fall-through).
REQ-007 SHALL provide port rx_valid  output  1  high when the FIFO is not empty.
REQ-008 SHALL provide port rx_ready  input  1  consumer accepts rx_data when rx_valid and rx_ready are both high on a clk edge.
REQ-009 SHALL provide port frame_err  output  1  one-cycle pulse when a stop bit samples 0.
REQ-010 SHALL provide port overrun_err  output  1  one-cycle pulse when a received byte is dropped because the FIFO is full.
REQ-011 SHALL provide port fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-012 SHALL pass rx_i through a 2-flop synchronizer and use only the synchronized value rx_s.
REQ-013 SHALL implement FSM states IDLE, START, DATA and STOP with a bit-period counter and a 3-bit bit index.
REQ-014 SHALL, in IDLE, move to START only on a 1->0 transition of rx_s; a line held low gives no start.
REQ-015 SHALL, in START, sample rx_s when the counter reaches CLKS_PER_BIT/2-1 (integer division): 0 -> DATA with counter and index cleared; 1 -> IDLE (glitch rejected, nothing pushed).
REQ-016 SHALL, in DATA, sample rx_s each time the counter reaches CLKS_PER_BIT-1, shift it in LSB first, then clear the counter; after the 8th bit, go to STOP.
REQ-017 SHALL, in STOP, sample rx_s at counter CLKS_PER_BIT-1: 1 -> push the byte; 0 -> pulse frame_err and discard the byte; return to IDLE in both cases.
REQ-018 SHALL accept a new start edge on the cycle after returning to IDLE.
REQ-019 SHALL pop one entry on each clk edge where rx_valid && rx_ready; rx_data and rx_valid reflect the new head on the following cycle.
REQ-020 SHALL, on a push into an empty FIFO, assert rx_valid with the new byte on the cycle after the push edge.
REQ-021 SHALL, on a push while full with no pop, drop the byte, pulse overrun_err, and leave FIFO contents and fifo_count unchanged.
REQ-022 SHALL, on a push and pop in the same cycle, accept both, including when full; fifo_count is unchanged and overrun_err stays 0.
REQ-023 SHALL ignore a pop while empty; fifo_count stays 0.
REQ-024 SHALL wrap read and write pointers modulo FIFO_DEPTH and preserve byte order.
REQ-025 SHALL allow frame_err and overrun_err to pulse only on a STOP-sample cycle, never both together, and never for longer than 1 cycle.

Reset
REQ-026 SHALL, while rst_n=0 (at any time, including mid-frame), force FSM=IDLE, counter=0, bit index=0, synchronizer flops=1, FIFO pointers=0, fifo_count=0, rx_valid=0, rx_data=0x00, frame_err=0, overrun_err=0.
REQ-027 SHALL discard any partial frame at reset and receive correctly from the first clean start edge after rst_n rises.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-028 SHALL cover: rx_ready=1, send 0xA5 8N1 -> one rx_valid cycle with rx_data=0xA5, frame_err=0, overrun_err=0, fifo_count returns to 0.
REQ-029 SHALL cover: rx_i low for 4 cycles, then high -> no rx_valid, no error pulse, FSM back in IDLE; a following 0x5A is received correctly.
REQ-030 SHALL cover: send 0x3C with stop bit 0 -> exactly one frame_err pulse, fifo_count=0; after the line returns high, 0x11 is received correctly.
REQ-031 SHALL cover: rx_ready=0, send 0x01..0x05 -> fifo_count=4, one overrun_err pulse at the 5th stop sample; then rx_ready=1 pops 0x01, 0x02, 0x03, 0x04 in order.
REQ-032 SHALL cover: FIFO full, rx_ready=1 asserted on the exact STOP-sample push cycle of 0x77 -> fifo_count stays 4, overrun_err=0, 0x77 is popped last.
REQ-033 SHALL cover: rst_n pulsed low during data bit 4 -> all outputs 0 within the reset, no byte emitted; a following 0xC3 is received correctly.
